alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Multi-byte sequencer for the 8-bit ALU: runs one ALU op over an N-byte word, LSB first.
//  Carry chains from flags[1] of byte k into carry_in of byte k+1.
//  Operand bytes arrive on a valid/ready stream; result bytes leave on another.
//  Whole-word flags are reported at the end. Sits between the microcode sequencer and the ALU.
// PARAMETERS
//  SETTLE   default 2   cycles ALU inputs are held stable before result/flags are sampled (>=1)
//  MAXLEN   default 8   max bytes per command; cmd_len is width $clog2(MAXLEN)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous reset, active-high
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   sequencer idle, accepts command
//  cmd_op      in   4   ALU op code, passed to alu_op
//  cmd_len     in   3   byte count minus 1 (0 = 1 byte)
//  cmd_carry   in   1   carry_in for byte 0
//  cmd_invert  in   1   passed to alu_invert for whole command
//  opd_valid   in   1   operand byte pair offered
//  opd_ready   out  1   operand accepted this cycle
//  opd_a       in   8   operand A byte
//  opd_b       in   8   operand B byte
//  alu_a       out  8   to ALU a (registered)
//  alu_b       out  8   to ALU b (registered)
//  alu_op      out  4   to ALU op (registered)
//  alu_n_oe    out  1   to ALU n_oe, low only in DRIVE
//  alu_invert  out  1   to ALU invert
//  alu_cin     out  1   to ALU carry_in
//  alu_result  in   8   from ALU result
//  alu_flags   in   4   from ALU flags {V,S,C,Z}
//  res_valid   out  1   result byte valid
//  res_ready   in   1   consumer accepts result byte
//  res_data    out  8   result byte
//  res_last    out  1   marks final byte of word
//  done        out  1   one-cycle pulse after last byte is accepted
//  word_flags  out  4   {V,S,C,Z} of whole word, valid when done=1, held until next cmd
// BEHAVIOUR
//  Reset: state IDLE. cmd_ready=1. alu_n_oe=1. All other outputs 0. Byte counter 0, settle counter 0.
//  FSM:
//   IDLE  : cmd_valid&cmd_ready -> latch op/len/carry/invert; set Zacc=1; go LOAD.
//   LOAD  : opd_ready=1. On opd_valid, register a/b into alu_a/alu_b. alu_cin = cmd_carry (byte 0) or chained C. Go DRIVE.
//   DRIVE : alu_n_oe=0 for exactly SETTLE cycles. On last cycle, sample alu_result -> res_data and alu_flags -> chain regs. Go EMIT.
//   EMIT  : res_valid=1 and alu_n_oe=1; hold until res_ready. res_last=1 when byte count == len.
//           If last -> DONE, else count+1 -> LOAD.
//   DONE  : done=1 for one cycle -> IDLE.
//  Flag rules:
//   Z = AND of per-byte Z over all bytes.
//   C, S, V taken from the final byte only.
//   Chained carry = sampled flags[1]; it feeds the next byte for every op (the ALU ignores it where unused).
//  Throughput: 1 byte per (SETTLE+2) cycles with zero backpressure. Latency cmd -> first res_valid = SETTLE+2.
//  Boundaries:
//   cmd_len=0 gives a single byte with res_last=1.
//   cmd_len=MAXLEN-1 does not wrap the counter.
//   cmd_valid outside IDLE is ignored (cmd_ready=0).
//   opd_valid outside LOAD is not consumed.
//   res_data is stable while res_valid & ~res_ready.
//   rst mid-command drops the word with no done pulse and no further res_valid.
//   rst and cmd_valid in the same cycle: rst wins.
// CONFIGURATION
//  ALU_SEQ_ABORT_EN defined:
//   Adds input port abort (1 bit).
//   abort=1 in LOAD/DRIVE/EMIT -> next cycle IDLE with alu_n_oe=1, res_valid=0, done pulse, word_flags=0.
//   abort in IDLE/DONE is ignored.
//  Undefined: no abort port; a command always runs to completion or rst.
// STRUCTURE
//  Shared include alu_seq_defs.vh:
//   state encodings S_IDLE..S_DONE, flag bit indices F_Z/F_C/F_S/F_V,
//   ALU op constants (OP_ADD=4'b1000, OP_ADC=4'b1010, OP_SUB=4'b1100, OP_SBC=4'b1110).
//  One sub-module alu_seq_flagacc: per-byte flag capture, Z accumulation, C chaining, final flag latch.
// TESTING (bench instantiates the real ALU, SETTLE=2)
//  1. ADD, len=1, A=0x01FF, B=0x0001, cin=0 -> bytes 0x00, 0x02; res_last on byte 1; flags C=0 Z=0.
//  2. ADC, len=1, A=0xFFFF, B=0x0000, cin=1 -> bytes 0x00, 0x00; word_flags Z=1, C=1, S=0.
//  3. ADD, len=0, 0x7F+0x01 -> 0x80; V=1, S=1, C=0; done exactly one cycle after res accepted.
//  4. res_ready held low 5 cycles on byte 0 -> res_data stable; opd_ready stays 0; no byte lost.
//  5. rst asserted in DRIVE of byte 1 of 4 -> next cycle cmd_ready=1, alu_n_oe=1, no done, no res_valid.
//  6. (ALU_SEQ_ABORT_EN) abort in EMIT of byte 2 of 8 -> done pulse next cycle, word_flags=0, IDLE.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the multi-byte ALU sequencer.
// Holds the FSM state encoding, the flag bit positions of the ALU flag
// nibble {V,S,C,Z}, the ALU op codes and the whole-word flag merge helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRIVE = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_S = 2;
  localparam int F_V = 3;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_ADC = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_SBC = 4'b1110;

  // Whole-word flags: C/S/V come from the final byte, Z is the running AND
  // of every byte's Z including the final one.
  function automatic logic [3:0] final_flags(input logic [3:0] f, input logic zacc);
    logic [3:0] r;
    r      = '0;
    r[F_V] = f[F_V];
    r[F_S] = f[F_S];
    r[F_C] = f[F_C];
    r[F_Z] = zacc & f[F_Z];
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_flagacc.sv
// alu_seq_flagacc: per-byte flag capture for the sequencer.
// Accumulates Z across the word, forwards the carry of each byte to the next
// and latches the whole-word flags when the final byte is sampled.
module alu_seq_flagacc
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,     // new command accepted
  input  logic       sample_i,    // ALU flags valid this cycle
  input  logic       last_i,      // sampled byte is the final one
  input  logic       clear_i,     // drop word flags (abort)
  input  logic [3:0] flags_i,
  output logic       chain_c_o,
  output logic [3:0] word_flags_o
);

  logic       zacc_q;
  logic       chain_c_q;
  logic [3:0] word_flags_q;

  // Flag accumulation; word flags stay put until the next command starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      zacc_q       <= 1'b0;
      chain_c_q    <= 1'b0;
      word_flags_q <= 4'h0;
    end else if (clear_i) begin
      word_flags_q <= 4'h0;
    end else if (start_i) begin
      zacc_q       <= 1'b1;
      chain_c_q    <= 1'b0;
      word_flags_q <= 4'h0;
    end else if (sample_i) begin
      zacc_q    <= zacc_q & flags_i[F_Z];
      chain_c_q <= flags_i[F_C];
      if (last_i) begin
        word_flags_q <= final_flags(flags_i, zacc_q);
      end
    end
  end

  assign chain_c_o    = chain_c_q;
  assign word_flags_o = word_flags_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: runs one 8-bit ALU op over an N-byte word, LSB first, chaining
// carry between bytes. Operands arrive and results leave on valid/ready
// streams; whole-word flags are reported with a one-cycle done pulse.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort input.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int SETTLE = 2,
  parameter  int MAXLEN = 8,
  localparam int LW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ALU_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_carry,
  input  logic          cmd_invert,
  input  logic          opd_valid,
  output logic          opd_ready,
  input  logic [7:0]    opd_a,
  input  logic [7:0]    opd_b,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_op,
  output logic          alu_n_oe,
  output logic          alu_invert,
  output logic          alu_cin,
  input  logic [7:0]    alu_result,
  input  logic [3:0]    alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic          res_last,
  output logic          done,
  output logic [3:0]    word_flags
);

  localparam int SW = $clog2(SETTLE + 1);

  state_e        state_q, state_d;
  logic [3:0]    op_q;
  logic [LW-1:0] len_q;
  logic          carry_q;
  logic          invert_q;
  logic [LW-1:0] cnt_q;
  logic [SW-1:0] settle_q;
  logic [7:0]    a_q, b_q;
  logic          cin_q;
  logic [7:0]    res_data_q;
  logic          abort_done_q;

  logic abort_hit, cmd_take, opd_take, res_take, settle_done, is_last, chain_c;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_hit = abort & (state_q inside {S_LOAD, S_DRIVE, S_EMIT});
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_ready   = (state_q == S_IDLE);
  assign opd_ready   = (state_q == S_LOAD) & ~abort_hit;
  assign res_valid   = (state_q == S_EMIT);
  assign is_last     = (cnt_q == len_q);
  assign res_last    = res_valid & is_last;
  assign alu_n_oe    = (state_q != S_DRIVE);
  assign cmd_take    = cmd_ready & cmd_valid;
  assign opd_take    = opd_ready & opd_valid;
  assign res_take    = res_valid & res_ready & ~abort_hit;
  assign settle_done = (state_q == S_DRIVE) & (settle_q == SW'(SETTLE - 1));
  // An aborted word still gets a done pulse, one cycle after the abort.
  assign done        = (state_q == S_DONE) | abort_done_q;

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_invert = invert_q;
  assign alu_cin    = cin_q;
  assign res_data   = res_data_q;

  // Next-state logic; abort overrides every handshake-driven transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid)   state_d = S_LOAD;
      S_LOAD:  if (opd_valid)   state_d = S_DRIVE;
      S_DRIVE: if (settle_done) state_d = S_EMIT;
      S_EMIT:  if (res_ready)   state_d = is_last ? S_DONE : S_LOAD;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // State register and the delayed done pulse for aborted words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      abort_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      abort_done_q <= abort_hit;
    end
  end

  // Command latch: op, length, initial carry and invert for the whole word.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 4'h0;
      len_q    <= '0;
      carry_q  <= 1'b0;
      invert_q <= 1'b0;
    end else if (cmd_take) begin
      op_q     <= cmd_op;
      len_q    <= cmd_len;
      carry_q  <= cmd_carry;
      invert_q <= cmd_invert;
    end
  end

  // ALU input registers and settle timer; byte 0 takes the command carry,
  // later bytes take the carry captured from the previous byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cin_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      if (opd_take) begin
        a_q      <= opd_a;
        b_q      <= opd_b;
        cin_q    <= (cnt_q == '0) ? carry_q : chain_c;
        settle_q <= '0;
      end else if (state_q == S_DRIVE) begin
        settle_q <= settle_done ? '0 : settle_q + SW'(1);
      end
    end
  end

  // Byte counter and result holding register; the counter only advances on
  // non-final bytes, so it never wraps even at the maximum length.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      res_data_q <= 8'h00;
    end else begin
      if (cmd_take) begin
        cnt_q <= '0;
      end else if (res_take && !is_last) begin
        cnt_q <= cnt_q + LW'(1);
      end
      if (settle_done && !abort_hit) begin
        res_data_q <= alu_result;
      end
    end
  end

  alu_seq_flagacc u_flagacc (
    .clk          (clk),
    .rst          (rst),
    .start_i      (cmd_take),
    .sample_i     (settle_done & ~abort_hit),
    .last_i       (is_last),
    .clear_i      (abort_hit),
    .flags_i      (alu_flags),
    .chain_c_o    (chain_c),
    .word_flags_o (word_flags)
  );

endmodule
